// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the registered immediate generator.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_state_e;

  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: extracts, extends and classifies the immediate
// of one instruction and forms the PC-relative target.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output imm_type_e       imm_type,
  output logic [XLEN-1:0] target,
  output logic            illegal
);

  logic signed [31:0]     imm32;
  logic signed [XLEN-1:0] imm_s;
  logic                   pc_rel;
  logic                   sgn;

  always_comb begin
    imm32    = '0;
    imm_type = IMM_NONE;
    illegal  = 1'b0;
    pc_rel   = 1'b0;
    sgn      = instr[31];
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OP: imm_type = IMM_NONE;
        OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_MISCMEM: begin
          imm_type = IMM_I;
          imm32    = {{20{sgn}}, instr[31:20]};
        end
        OPC_OPIMM32: begin
          if (XLEN == 64) begin
            imm_type = IMM_I;
            imm32    = {{20{sgn}}, instr[31:20]};
          end else begin
            illegal = 1'b1;
          end
        end
        OPC_STORE: begin
          imm_type = IMM_S;
          imm32    = {{20{sgn}}, instr[31:25], instr[11:7]};
        end
        OPC_BRANCH: begin
          imm_type = IMM_B;
          pc_rel   = 1'b1;
          imm32    = {{19{sgn}}, sgn, instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_JAL: begin
          imm_type = IMM_J;
          pc_rel   = 1'b1;
          imm32    = {{11{sgn}}, sgn, instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          imm_type = IMM_U;
          pc_rel   = (instr[6:0] == OPC_AUIPC);
          imm32    = {instr[31:12], 12'b0};
        end
        OPC_SYSTEM: begin
          // CSR immediate forms carry an unsigned 5-bit value in the rs1 field
          if (instr[14] && EN_ZIMM) begin
            imm_type = IMM_Z;
            imm32    = {27'b0, instr[19:15]};
          end else begin
            imm_type = IMM_I;
            imm32    = {{20{sgn}}, instr[31:20]};
          end
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  assign imm_s  = XLEN'(imm32);
  assign imm    = imm_s;
  assign target = pc_rel ? (pc + imm_s) : '0;

endmodule

// File: rtl/imm_gen_pipe.sv
// Handshaked immediate generator: decode on accept into a main register backed
// by a one-entry skid register so o_ready depends only on flops.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit EN_ZIMM = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic [XLEN-1:0] o_pc_target,
  output logic            o_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_type_e       typ;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  occ_state_e state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     dec;
  logic       accept, emit;

  imm_decode #(.XLEN(XLEN), .EN_ZIMM(EN_ZIMM)) u_dec (
    .instr    (i_instr),
    .pc       (i_pc),
    .imm      (dec.imm),
    .imm_type (dec.typ),
    .target   (dec.target),
    .illegal  (dec.illegal)
  );

  assign accept = i_valid && o_ready;
  assign emit   = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= OCC_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      OCC_EMPTY: begin
        if (accept) begin
          state_d = OCC_ONE;
          main_d  = dec;
        end
      end
      OCC_ONE: begin
        if (accept && emit) begin
          main_d = dec;
        end else if (accept) begin
          state_d = OCC_TWO;
          skid_d  = dec;
        end else if (emit) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (emit) begin
          state_d = OCC_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    // Flush overrides any accept or emit in the same cycle
    if (i_flush) state_d = OCC_EMPTY;
  end

  always_comb begin
    o_valid     = (state_q != OCC_EMPTY);
    o_ready     = (state_q != OCC_TWO);
    o_imm       = main_q.imm;
    o_imm_type  = main_q.typ;
    o_pc_target = main_q.target;
    o_illegal   = main_q.illegal;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, handshaked immediate generator for the next-generation decode stage.
- Decodes the immediate from a 32-bit base-ISA instruction and sign-extends it to XLEN (32 or 64).
- Adds immediate-type classification, an illegal-opcode flag and a PC-relative target.
- Sits between fetch/instruction buffer and execute, with a valid/ready interface on both sides and a 2-entry skid buffer so back-pressure is fully registered.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- EN_ZIMM, 1, 1 = SYSTEM CSR*I forms yield the zero-extended rs1-field immediate (Z type).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous reset, active-low
- i_flush  input  1  discard all buffered entries
- i_valid  input  1  upstream instruction valid
- o_ready  output  1  block can accept (registered)
- i_instr  input  32  instruction word
- i_pc  input  XLEN  PC of i_instr
- o_valid  output  1  output entry valid
- i_ready  input  1  downstream accepts
- o_imm  output  XLEN  extended immediate
- o_imm_type  output  3  imm_type_e
- o_pc_target  output  XLEN  i_pc + o_imm for B/J/AUIPC, else 0
- o_illegal  output  1  opcode unsupported

Behaviour:
- Handshakes:
  - Accept on i_valid && o_ready.
  - Emit on o_valid && i_ready.
  - Latency 1 cycle: an accepted instruction appears on the outputs the next cycle when the block is empty.
- State machine (occupancy):
  - EMPTY: o_valid=0, o_ready=1. Accept → ONE.
  - ONE: main register holds an entry, o_valid=1, o_ready=1.
    - Accept without emit → TWO (new entry into skid).
    - Emit without accept → EMPTY.
    - Accept and emit → ONE (main reloads).
  - TWO: main and skid full, o_valid=1, o_ready=0. Emit → ONE; skid moves to main the same edge.
  - Strict FIFO order. Outputs are stable while o_valid && !i_ready.
- Flush:
  - i_flush=1 → EMPTY next edge; both entries dropped.
  - An input accepted in the flush cycle is discarded.
  - Flush has priority over accept and emit.
- Reset (i_rst_n=0 at an edge):
  - State EMPTY, o_valid=0, o_ready=1, o_imm=0, o_imm_type=IMM_NONE, o_pc_target=0, o_illegal=0.
  - Applies identically mid-transfer.
- Decode on accept (registered, not on the output):
  - bits[1:0]!=2'b11 → illegal.
  - OP 0110011 → NONE, imm 0.
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, MISC-MEM 0001111 → I: sext(instr[31:20]).
  - OP-IMM-32 0011011 → I when XLEN=64; illegal when XLEN=32.
  - STORE 0100011 → S: sext({instr[31:25], instr[11:7]}).
  - BRANCH 1100011 → B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - JAL 1101111 → J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - LUI 0110111, AUIPC 0010111 → U: sext({instr[31:12], 12'b0}). For XLEN=64, bit 31 fills [63:32].
  - SYSTEM 1110011:
    - funct3[2]=1 && EN_ZIMM → Z: zext(instr[19:15]).
    - Otherwise → I.
  - Any other opcode → illegal=1, type NONE, imm 0.
- Target:
  - o_pc_target = (i_pc + imm) mod 2^XLEN for B, J and AUIPC.
  - 0 for all other instructions, including JALR (rs1 is unknown here).
- Sign extension always uses instr[31] and fills to XLEN.

Decomposition:
- Package imm_gen_pkg holds:
  - typedef enum logic[2:0] imm_type_e: IMM_NONE=0, IMM_I=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5, IMM_Z=6.
  - Opcode localparams: OPC_OP, OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_MISCMEM.
- One combinational sub-module, imm_decode (instr, pc → imm, type, target, illegal), parametrised by XLEN and EN_ZIMM. Top holds only the skid/occupancy logic.

Test Plan:
- XLEN=32, i_ready=1, 0xFFF00093 (addi x1,x0,-1) → next cycle o_valid=1, o_imm=0xFFFFFFFF, o_imm_type=IMM_I, o_illegal=0.
- 0xFE000EE3 (beq -4), i_pc=0x100 → o_imm=0xFFFFFFFC, IMM_B, o_pc_target=0x000000FC.
- XLEN=64:
  - 0x800000B7 (lui) → o_imm=0xFFFFFFFF80000000, IMM_U.
  - 0x0000001B → IMM_I, not illegal. The same word with XLEN=32 → o_illegal=1, o_imm=0.
- 0x300FD073 (csrrwi, zimm 31) with EN_ZIMM=1 → o_imm=0x1F, IMM_Z.
- Back-pressure:
  - With i_ready=0, offer three instructions back-to-back → first two accepted, o_ready=0 after the second, third held upstream.
  - Raise i_ready → outputs appear in order 1,2,3, and o_ready returns to 1 one cycle after the first emit.
- Flush/reset/illegal:
  - Fill to TWO, pulse i_flush → o_valid=0 and o_ready=1 next cycle, no stale emit.
  - Repeat with i_rst_n=0 → all outputs 0.
  - 0x0000000B → o_illegal=1. 0x00000001 → o_illegal=1.
